// File: rtl/ikascc_slot_bus_initiator_if.sv
// ikascc_slot_bus_initiator_if: request/response handshake and MSX slot bus pins
interface ikascc_slot_bus_initiator_if;
  logic        i_REQ_VALID;
  logic        o_REQ_READY;
  logic        i_REQ_WR;
  logic [15:0] i_REQ_ADDR;
  logic [7:0]  i_REQ_WDATA;
  logic        o_RSP_VALID;
  logic [7:0]  o_RSP_RDATA;
  logic        o_CS_n;
  logic        o_WR_n;
  logic        o_RD_n;
  logic [4:0]  o_ABHI;
  logic [7:0]  o_ABLO;
  logic [7:0]  o_DB_OUT;
  logic        o_DB_OE;
  logic [7:0]  i_DB_IN;
  modport master (
    input  i_REQ_VALID, i_REQ_WR, i_REQ_ADDR, i_REQ_WDATA, i_DB_IN,
    output o_REQ_READY, o_RSP_VALID, o_RSP_RDATA, o_CS_n, o_WR_n, o_RD_n,
           o_ABHI, o_ABLO, o_DB_OUT, o_DB_OE
  );
  modport slave (
    output i_REQ_VALID, i_REQ_WR, i_REQ_ADDR, i_REQ_WDATA, i_DB_IN,
    input  o_REQ_READY, o_RSP_VALID, o_RSP_RDATA, o_CS_n, o_WR_n, o_RD_n,
           o_ABHI, o_ABLO, o_DB_OUT, o_DB_OE
  );
endinterface

// File: rtl/ikascc_slot_bus_initiator.sv
// ikascc_slot_bus_initiator: turns valid/ready requests into timed CS_n/WR_n/RD_n slot bus cycles
module ikascc_slot_bus_initiator #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input logic i_CLK,
  input logic i_RST,
  ikascc_slot_bus_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [4:0] abhi_q, abhi_d;
  logic [7:0] ablo_q, ablo_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       db_oe_q, db_oe_d;
  logic       accept;
  logic       last;
  assign accept = bus.i_REQ_VALID && req_ready_q;
  assign last   = cnt_q == 4'd0;
  // State, latched request and registered bus outputs
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      abhi_q      <= 5'd0;
      ablo_q      <= 8'd0;
      wdata_q     <= 8'd0;
      rsp_rdata_q <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      db_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      abhi_q      <= abhi_d;
      ablo_q      <= ablo_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      db_oe_q     <= db_oe_d;
    end
  end
  // Next state: each phase counts down from its length minus one; request latched only on accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 4'd1;
    wr_d    = wr_q;
    abhi_d  = abhi_q;
    ablo_d  = ablo_q;
    wdata_d = wdata_q;
    if (state_q == IDLE) begin
      cnt_d = cnt_q;
      if (accept) begin
        state_d = SETUP;
        cnt_d   = 4'(SETUP_CYC - 1);
        wr_d    = bus.i_REQ_WR;
        abhi_d  = bus.i_REQ_ADDR[15:11];
        ablo_d  = bus.i_REQ_ADDR[7:0];
        wdata_d = bus.i_REQ_WDATA;
      end
    end else if (last) begin
      state_d = (state_q == SETUP) ? STROBE : (state_q == STROBE) ? HOLD : IDLE;
      cnt_d   = (state_q == SETUP) ? 4'(STROBE_CYC - 1) : (state_q == STROBE) ? 4'(HOLD_CYC - 1) : 4'd0;
    end
  end
  // Outputs follow the state being entered so every pin is a flop aligned with the state
  always_comb begin
    req_ready_d = state_d == IDLE;
    cs_n_d      = state_d == IDLE;
    wr_n_d      = !(state_d == STROBE && wr_d);
    rd_n_d      = !(state_d == STROBE && !wr_d);
    db_oe_d     = state_d != IDLE && wr_d;
    rsp_valid_d = state_q == HOLD && last;
    rsp_rdata_d = (state_q == STROBE && last && !wr_q) ? bus.i_DB_IN : rsp_rdata_q;
  end
  assign bus.o_REQ_READY = req_ready_q;
  assign bus.o_RSP_VALID = rsp_valid_q;
  assign bus.o_RSP_RDATA = rsp_rdata_q;
  assign bus.o_CS_n      = cs_n_q;
  assign bus.o_WR_n      = wr_n_q;
  assign bus.o_RD_n      = rd_n_q;
  assign bus.o_ABHI      = abhi_q;
  assign bus.o_ABLO      = ablo_q;
  assign bus.o_DB_OUT    = wdata_q;
  assign bus.o_DB_OE     = db_oe_q;
endmodule

// File: tb/tb_ikascc_slot_bus_initiator.sv
// tb_ikascc_slot_bus_initiator: vector table, corner sequences and random traffic against a cycle-position model
module tb_ikascc_slot_bus_initiator;
  localparam int S = 2, ST = 3, H = 1, T = S + ST + H;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  ikascc_slot_bus_initiator_if bus ();
  ikascc_slot_bus_initiator_if bus1 ();
  ikascc_slot_bus_initiator dut (.i_CLK(clk), .i_RST(rst), .bus(bus));
  ikascc_slot_bus_initiator #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut1 (.i_CLK(clk), .i_RST(rst), .bus(bus1));
  int checks = 0;
  int failures = 0;
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference model: position within the transaction (0 = idle, 1..T = clocks since accept)
  int pos = 0;
  logic m_wr = 0;
  logic [15:0] m_addr = 0;
  logic [7:0] m_wdata = 0, m_rdata = 0;
  logic m_rsp = 0;
  bit model_on = 0;
  always @(posedge clk) begin
    if (rst) begin
      pos = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_rsp = 0;
    end else begin
      m_rsp = (pos == T);
      if (pos == S + ST && !m_wr) m_rdata = bus.i_DB_IN;
      if (pos == 0 && bus.i_REQ_VALID) begin
        pos = 1; m_wr = bus.i_REQ_WR; m_addr = bus.i_REQ_ADDR; m_wdata = bus.i_REQ_WDATA;
      end else if (pos == T) pos = 0;
      else if (pos > 0) pos++;
    end
  end
  always @(negedge clk) begin
    logic strb, busy;
    if (model_on) begin
      busy = pos != 0;
      strb = pos > S && pos <= S + ST;
      chk("model", {bus.o_REQ_READY, bus.o_CS_n, bus.o_WR_n, bus.o_RD_n, bus.o_DB_OE, bus.o_RSP_VALID,
                    bus.o_ABHI, bus.o_ABLO, bus.o_DB_OUT, bus.o_RSP_RDATA},
                   {!busy, !busy, !(strb && m_wr), !(strb && !m_wr), busy && m_wr, m_rsp,
                    m_addr[15:11], m_addr[7:0], m_wdata, m_rdata});
    end
  end
  typedef struct {
    logic wr; logic [15:0] addr; logic [7:0] wdata; logic [7:0] dbin;
    logic [4:0] abhi; logic [7:0] ablo; logic [7:0] rdata;
  } vec_t;
  vec_t vecs[4];
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.o_REQ_READY && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_wait"}, 48'(bus.o_REQ_READY), 48'd1);
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    int cs_low = 0, stb = 0, other = 0, first = 0, oe = 0, lat = 0, pulses = 0, bad = 0;
    logic [7:0] rd = 0;
    wait_ready(nm);
    bus.i_REQ_VALID = 1; bus.i_REQ_WR = v.wr; bus.i_REQ_ADDR = v.addr;
    bus.i_REQ_WDATA = v.wdata; bus.i_DB_IN = v.dbin;
    for (int k = 1; k <= T + 3; k++) begin
      @(negedge clk);
      bus.i_REQ_VALID = 0;
      if (!bus.o_CS_n) begin
        cs_low++;
        if (bus.o_ABHI !== v.abhi || bus.o_ABLO !== v.ablo || (v.wr && bus.o_DB_OUT !== v.wdata)) bad++;
      end
      if (!(v.wr ? bus.o_WR_n : bus.o_RD_n)) begin
        stb++;
        if (first == 0) first = k;
      end
      if (!(v.wr ? bus.o_RD_n : bus.o_WR_n)) other++;
      if (bus.o_DB_OE) oe++;
      if (bus.o_RSP_VALID) begin
        pulses++;
        if (lat == 0) lat = k;
        rd = bus.o_RSP_RDATA;
      end
    end
    chk({nm, "_cs_low"}, 48'(cs_low), 48'(T));
    chk({nm, "_strobe_low"}, 48'(stb), 48'(ST));
    chk({nm, "_strobe_first"}, 48'(first), 48'(S + 1));
    chk({nm, "_other_strobe"}, 48'(other), 48'd0);
    chk({nm, "_oe"}, 48'(oe), v.wr ? 48'(T) : 48'd0);
    chk({nm, "_bus_stable"}, 48'(bad), 48'd0);
    chk({nm, "_rsp_lat"}, 48'(lat), 48'(T + 1));
    chk({nm, "_rsp_pulses"}, 48'(pulses), 48'd1);
    chk({nm, "_rdata"}, 48'(rd), 48'(v.rdata));
  endtask
  initial begin
    logic [13:0] csv, rdyv;
    logic [4:0] hi1, hi2, c1, w1, r1;
    logic [7:0] db1, db2;
    int seen;
    vecs[0] = '{1'b1, 16'h9000, 8'h3F, 8'h00, 5'h12, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 16'h9880, 8'h00, 8'hA5, 5'h13, 8'h80, 8'hA5};
    vecs[2] = '{1'b1, 16'h5000, 8'h04, 8'h77, 5'h0A, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 16'h1234, 8'h00, 8'h5A, 5'h02, 8'h34, 8'h5A};
    bus.i_REQ_VALID = 0; bus.i_REQ_WR = 0; bus.i_REQ_ADDR = 0; bus.i_REQ_WDATA = 0; bus.i_DB_IN = 0;
    bus1.i_REQ_VALID = 0; bus1.i_REQ_WR = 0; bus1.i_REQ_ADDR = 0; bus1.i_REQ_WDATA = 0; bus1.i_DB_IN = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.o_REQ_READY, bus.o_CS_n, bus.o_WR_n, bus.o_RD_n, bus.o_DB_OE, bus.o_RSP_VALID,
                        bus.o_ABHI, bus.o_ABLO, bus.o_DB_OUT, bus.o_RSP_RDATA},
                       {6'b111100, 5'd0, 8'd0, 8'd0, 8'd0});
    chk("reset_state_min", {bus1.o_REQ_READY, bus1.o_CS_n, bus1.o_WR_n, bus1.o_RD_n, bus1.o_DB_OE, bus1.o_RSP_VALID},
                           48'b111100);
    rst = 0;
    model_on = 1;
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    wait_ready("b2b");
    bus.i_REQ_VALID = 1; bus.i_REQ_WR = 1; bus.i_REQ_ADDR = 16'h5000; bus.i_REQ_WDATA = 8'h04;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.i_REQ_ADDR = 16'h7000; bus.i_REQ_WDATA = 8'h05; end
      if (k == 8) bus.i_REQ_VALID = 0;
      csv[k-1] = bus.o_CS_n;
      rdyv[k-1] = bus.o_REQ_READY;
      if (k == 3) begin hi1 = bus.o_ABHI; db1 = bus.o_DB_OUT; end
      if (k == 9) begin hi2 = bus.o_ABHI; db2 = bus.o_DB_OUT; end
    end
    chk("b2b_cs_pattern", 48'(csv), 48'h2040);
    chk("b2b_ready_pattern", 48'(rdyv), 48'h2040);
    chk("b2b_first", {hi1, db1}, {5'h0A, 8'h04});
    chk("b2b_second", {hi2, db2}, {5'h0E, 8'h05});
    wait_ready("churn");
    bus.i_REQ_VALID = 1; bus.i_REQ_WR = 1; bus.i_REQ_ADDR = 16'h9000; bus.i_REQ_WDATA = 8'h3F;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      chk($sformatf("churn_k%0d", k), {bus.o_CS_n, bus.o_ABHI, bus.o_ABLO, bus.o_DB_OUT}, {1'b0, 5'h12, 8'h00, 8'h3F});
      bus.i_REQ_VALID = (k < T) ? 1'($urandom % 2) : 1'b0;
      bus.i_REQ_WR = 1'($urandom);
      bus.i_REQ_ADDR = 16'($urandom);
      bus.i_REQ_WDATA = 8'($urandom);
    end
    repeat (T + 3) @(negedge clk);
    bus.i_REQ_VALID = 0;
    wait_ready("rst_mid");
    bus.i_REQ_VALID = 1; bus.i_REQ_WR = 1; bus.i_REQ_ADDR = 16'h9000; bus.i_REQ_WDATA = 8'h3F;
    @(negedge clk);
    bus.i_REQ_VALID = 0;
    repeat (S + 1) @(negedge clk);
    chk("rst_mid_pre_wr_n", 48'(bus.o_WR_n), 48'd0);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_state", {bus.o_WR_n, bus.o_CS_n, bus.o_DB_OE, bus.o_REQ_READY, bus.o_RSP_VALID}, 48'b11010);
    rst = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_RSP_VALID) seen++;
    end
    chk("rst_mid_no_rsp", 48'(seen), 48'd0);
    bus1.i_REQ_VALID = 1; bus1.i_REQ_WR = 1; bus1.i_REQ_ADDR = 16'h9000; bus1.i_REQ_WDATA = 8'h3F;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus1.i_REQ_VALID = 0;
      c1[k-1] = bus1.o_CS_n;
      w1[k-1] = bus1.o_WR_n;
      r1[k-1] = bus1.o_RSP_VALID;
    end
    chk("min_cs", 48'(c1), 48'b11000);
    chk("min_wr", 48'(w1), 48'b11101);
    chk("min_rsp", 48'(r1), 48'b01000);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 97) == 0;
      bus.i_REQ_VALID = ($urandom % 3) == 0;
      bus.i_REQ_WR = 1'($urandom);
      bus.i_REQ_ADDR = 16'($urandom);
      bus.i_REQ_WDATA = 8'($urandom);
      bus.i_DB_IN = 8'($urandom);
      @(negedge clk);
    end
    rst = 0;
    bus.i_REQ_VALID = 0;
    repeat (T + 3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
